// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store unit. Issues one word-aligned bus transaction
//            per access, stalls the pipeline until it completes or times out,
//            and returns sign/zero-extended load data.
//            Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nop,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        load_unsigned,
  input  logic        ls_byte,
  input  logic        half,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        bus_error
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]           c_SZ_WORD = 2'd0;
  localparam logic [1:0]           c_SZ_HALF = 2'd1;
  localparam logic [1:0]           c_SZ_BYTE = 2'd2;
  localparam logic [TIMEOUT_W-1:0] c_TIMEOUT = TIMEOUT_W'(TIMEOUT);

  state_t r_state, w_next;

  logic [31:0]          r_addr;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic                 r_is_load;
  logic [1:0]           r_off;
  logic [1:0]           r_size;
  logic                 r_uns;
  logic                 r_err;
  logic                 r_trap;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [31:0]          r_load_data;

  logic        w_start;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_trap_set;
  logic [31:0] w_ext;
  logic [7:0]  w_lane8;
  logic [15:0] w_lane16;

  logic w_capture;
  logic w_load_cap;
  logic w_timeout;
  logic w_cnt_inc;
  logic w_cnt_clr;

  assign w_start = ~nop & (mem_write | mem_to_reg);
  assign w_size  = ls_byte ? c_SZ_BYTE : (half ? c_SZ_HALF : c_SZ_WORD);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_size)
      c_SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      c_SZ_HALF: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap_set = ((w_size == c_SZ_HALF) & addr[0]) |
                      ((w_size == c_SZ_WORD) & (addr[1:0] != 2'b00));
`else
  assign w_trap_set = 1'b0;
`endif

  // Lane extraction works on the captured offset, so the request inputs may
  // already have moved on by the time the bus answers.
  assign w_lane8  = dmem_rdata[{r_off, 3'b000} +: 8];
  assign w_lane16 = dmem_rdata[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = dmem_rdata;
    case (r_size)
      c_SZ_BYTE: w_ext = {{24{~r_uns & w_lane8[7]}}, w_lane8};
      c_SZ_HALF: w_ext = {{16{~r_uns & w_lane16[15]}}, w_lane16};
      default:   w_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_load_cap = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_cnt_clr  = 1'b0;
    stall      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'd0;
    dmem_be    = 4'd0;
    dmem_wdata = 32'd0;
    load_valid = 1'b0;
    bus_error  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_trap = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Gated by rst_n so every output is quiet while reset is held.
        stall = rst_n & w_start;
        if (w_start) begin
          w_capture = 1'b1;
          w_next    = w_trap_set ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        stall      = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_addr  = r_addr;
        dmem_be    = r_be;
        dmem_wdata = r_wdata;
        if (dmem_ready) begin
          w_load_cap = r_is_load;
          w_next     = S_DONE;
        end else if (r_cnt == c_TIMEOUT) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        load_valid = r_is_load & ~r_err & ~r_trap;
        bus_error  = r_err;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_trap = r_trap;
`endif
        w_cnt_clr = 1'b1;
        w_next    = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= 32'd0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
      r_off       <= 2'd0;
      r_size      <= c_SZ_WORD;
      r_uns       <= 1'b0;
      r_err       <= 1'b0;
      r_trap      <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= 32'd0;
    end else begin
      if (w_capture) begin
        r_addr    <= {addr[31:2], 2'b00};
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_we      <= mem_write;
        r_is_load <= mem_to_reg & ~mem_write;
        r_off     <= addr[1:0];
        r_size    <= w_size;
        r_uns     <= load_unsigned;
        r_trap    <= w_trap_set;
      end
      if (w_load_cap) begin
        r_load_data <= w_ext;
      end
      if (w_timeout) begin
        r_err       <= 1'b1;
        r_load_data <= 32'd0;
      end
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_cnt_clr) begin
        r_cnt  <= '0;
        r_err  <= 1'b0;
        r_trap <= 1'b0;
      end
    end
  end

  assign load_data = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nop = 1'b1;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        mem_write = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic        load_unsigned = 1'b0;
  logic        ls_byte = 1'b0;
  logic        half = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ready = 1'b0;
  logic [31:0] load_data;
  logic        load_valid;
  logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] last_load = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nop          (nop),
    .addr         (addr),
    .store_data   (store_data),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .load_unsigned(load_unsigned),
    .ls_byte      (ls_byte),
    .half         (half),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .bus_error    (bus_error)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_trap(misalign_trap)
`endif
  );

  // Reference rules: byte lanes selected by address, then arithmetic extension.
  function automatic logic [3:0] model_be(input logic [31:0] a, input logic b, input logic h);
    if (b) return 4'(1 << a[1:0]);
    if (h) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic b, input logic h);
    if (b) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (h) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] r, input logic [31:0] a,
                                             input logic b, input logic h, input logic uns);
    logic [31:0] v;
    if (b) begin
      v = (r >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (h) begin
      v = (r >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // delay >= 0: dmem_ready on that BUSY cycle index; delay < 0: never ready.
  task automatic do_access(input logic st, input logic ld, input logic [31:0] a,
                           input logic [31:0] d, input logic uns, input logic b,
                           input logic h, input int delay, input logic [31:0] rdata,
                           input string nm, output int stalls, output int busy_cycles);
    logic is_load;
    logic [31:0] eaddr;
    logic [3:0] ebe;
    logic [31:0] ewd;
    logic [31:0] eload;
    logic bad;
    bit done;
    int cyc;
    is_load = ld & ~st;
    eaddr   = {a[31:2], 2'b00};
    ebe     = model_be(a, b, h);
    ewd     = model_wdata(d, b, h);
    eload   = model_load(rdata, a, b, h, uns);
    stalls  = 0;
    @(negedge clk);
    nop = 1'b0; mem_write = st; mem_to_reg = ld; addr = a; store_data = d;
    load_unsigned = uns; ls_byte = b; half = h; dmem_ready = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: stall=%b req=%b, want stall=1 req=0", nm, stall, dmem_req);
    end
    if (stall === 1'b1) stalls++;
    cyc = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      bad = (dmem_req !== 1'b1) || (stall !== 1'b1) || (dmem_we !== st) ||
            (dmem_addr !== eaddr) || (dmem_be !== ebe) || (st && dmem_wdata !== ewd);
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL %s busy[%0d]: req=%b stall=%b we=%b addr=%h be=%b wdata=%h, want 1 1 %b %h %b %h",
                 nm, cyc, dmem_req, stall, dmem_we, dmem_addr, dmem_be, dmem_wdata, st, eaddr, ebe, ewd);
      end
      if (stall === 1'b1) stalls++;
      if (dmem_req !== 1'b1) done = 1;
      if (cyc == delay) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        done = 1;
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
        if (delay < 0 && cyc >= 255) done = 1;
      end
      cyc++;
    end
    busy_cycles = cyc;
    @(negedge clk);
    dmem_ready = 1'b0;
    if (delay < 0) last_load = 32'd0;
    else if (is_load) last_load = eload;
    tests++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || bus_error !== (delay < 0) ||
        load_valid !== (is_load && delay >= 0) || load_data !== last_load) begin
      fails++;
      $display("FAIL %s done: stall=%b req=%b err=%b valid=%b data=%h, want 0 0 %b %b %h",
               nm, stall, dmem_req, bus_error, load_valid, load_data,
               delay < 0, is_load && delay >= 0, last_load);
    end
    nop = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b0;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || dmem_req !== 1'b0 || load_valid !== 1'b0 ||
        bus_error !== 1'b0 || load_data !== last_load) begin
      fails++;
      $display("FAIL %s after: stall=%b req=%b valid=%b err=%b data=%h, want 0 0 0 0 %h",
               nm, stall, dmem_req, load_valid, bus_error, load_data, last_load);
    end
  endtask

  task automatic test_reset();
    nop = 1'b0; mem_to_reg = 1'b1;
    #12;
    tests++;
    if ({stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, load_valid, bus_error} !== '0) begin
      fails++;
      $display("FAIL reset: stall=%b req=%b we=%b addr=%h be=%b wdata=%h data=%h valid=%b err=%b, want all 0",
               stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data, load_valid, bus_error);
    end
    @(negedge clk);
    nop = 1'b1; mem_to_reg = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_lb();
    int s, bc;
    do_access(1'b0, 1'b1, 32'h103, 32'h0, 1'b0, 1'b1, 1'b0, 0, 32'h80FF_1234, "lb", s, bc);
    tests++;
    if (s != 2 || load_data !== 32'hFFFF_FF80) begin
      fails++;
      $display("FAIL lb_latency: stalls=%0d data=%h, want 2 ffffff80", s, load_data);
    end
  endtask

  task automatic test_sh();
    int s, bc;
    do_access(1'b1, 1'b0, 32'h202, 32'h0000_ABCD, 1'b0, 1'b0, 1'b1, 3, 32'h0, "sh", s, bc);
    tests++;
    if (s != 5) begin
      fails++;
      $display("FAIL sh_stall: stalls=%0d, want 5", s);
    end
  endtask

  task automatic test_lhu();
    int s, bc;
    do_access(1'b0, 1'b1, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 0, 32'h1234_F00D, "lhu", s, bc);
    do_access(1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 1, 32'h1234_F00D, "lh", s, bc);
    tests++;
    if (load_data !== 32'hFFFF_F00D) begin
      fails++;
      $display("FAIL lh_signed: data=%h, want fffff00d", load_data);
    end
  endtask

  task automatic test_timeout();
    int s, bc;
    do_access(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, "lw_pre", s, bc);
    do_access(1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, -1, 32'h0, "lw_timeout", s, bc);
    tests++;
    if (bc != 256 || s != 257) begin
      fails++;
      $display("FAIL timeout_len: busy=%0d stalls=%0d, want 256 257", bc, s);
    end
  endtask

  task automatic test_async_reset();
    int s, bc;
    @(negedge clk);
    nop = 1'b0; mem_to_reg = 1'b1; addr = 32'h80; ls_byte = 1'b0; half = 1'b0;
    @(negedge clk);
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL arst_busy: req=%b, want 1", dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    last_load = 32'd0;
    tests++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
      fails++;
      $display("FAIL arst_drop: req=%b stall=%b data=%h, want 0 0 0", dmem_req, stall, load_data);
    end
    @(negedge clk);
    nop = 1'b1; mem_to_reg = 1'b0;
    rst_n = 1'b1;
    do_access(1'b0, 1'b1, 32'h81, 32'h0, 1'b1, 1'b1, 1'b0, 2, 32'h00AB_CD00, "post_rst", s, bc);
  endtask

  task automatic test_bubble();
    @(negedge clk);
    nop = 1'b1; mem_to_reg = 1'b1; mem_write = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (stall !== 1'b0 || dmem_req !== 1'b0 || load_valid !== 1'b0 || load_data !== last_load) begin
        fails++;
        $display("FAIL bubble[%0d]: stall=%b req=%b valid=%b data=%h, want 0 0 0 %h",
                 i, stall, dmem_req, load_valid, load_data, last_load);
      end
    end
    dmem_ready = 1'b0; mem_to_reg = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_misalign();
    int s, bc;
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    nop = 1'b0; mem_to_reg = 1'b1; mem_write = 1'b0; addr = 32'h6; ls_byte = 1'b0; half = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL trap_idle: stall=%b req=%b, want 1 0", stall, dmem_req);
    end
    @(negedge clk);
    tests++;
    if (misalign_trap !== 1'b1 || dmem_req !== 1'b0 || load_valid !== 1'b0 || stall !== 1'b0) begin
      fails++;
      $display("FAIL trap_done: trap=%b req=%b valid=%b stall=%b, want 1 0 0 0",
               misalign_trap, dmem_req, load_valid, stall);
    end
    nop = 1'b1; mem_to_reg = 1'b0;
    @(negedge clk);
    tests++;
    if (misalign_trap !== 1'b0) begin
      fails++;
      $display("FAIL trap_pulse: trap=%b, want 0", misalign_trap);
    end
`else
    do_access(1'b0, 1'b1, 32'h6, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h5566_7788, "lw_misal", s, bc);
    do_access(1'b0, 1'b1, 32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 0, 32'h8001_0203, "lh_misal", s, bc);
`endif
  endtask

  task automatic test_random();
    int s, bc;
    logic st, ld, b, h, uns;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      st  = 1'($urandom);
      ld  = 1'($urandom);
      if (!st && !ld) ld = 1'b1;
      b   = 1'($urandom);
      h   = 1'($urandom);
      uns = 1'($urandom);
      a   = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (!b && h) a[0] = 1'b0;
      if (!b && !h) a[1:0] = 2'b00;
`endif
      do_access(st, ld, a, $urandom, uns, b, h, int'($urandom_range(0, 6)), $urandom, "random", s, bc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_lhu();
    test_bubble();
    test_timeout();
    test_async_reset();
    test_misalign();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Converts each load or store into a word-aligned data-memory bus transaction with a req/ready handshake.
- Holds the pipeline stalled until the transaction completes.
- Returns byte, half or word load data, sign- or zero-extended, to the MEM/WB path; a timeout counter bounds every transaction.

Parameters:
- TIMEOUT, 255: max cycles in BUSY waiting for dmem_ready before the transaction is aborted.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- nop  in  1  current EX/MEM entry is a bubble.
- addr  in  32  effective address (ALU result).
- store_data  in  32  rs2 value for stores.
- mem_write  in  1  store request.
- mem_to_reg  in  1  load request.
- load_unsigned  in  1  zero-extend load.
- ls_byte  in  1  byte access.
- half  in  1  halfword access.
- stall  out  1  freeze all upstream pipeline registers.
- dmem_req  out  1  bus request.
- dmem_we  out  1  bus write enable.
- dmem_addr  out  32  word-aligned bus address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated write data.
- dmem_rdata  in  32  bus read data, valid with dmem_ready.
- dmem_ready  in  1  bus completes the transaction this cycle.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse, load_data valid.
- bus_error  out  1  one-cycle pulse, transaction timed out.

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. While rst_n=0, every output is 0, state is IDLE and the timeout counter is 0.
- An access starts when `~nop & (mem_write | mem_to_reg)`. If both mem_write and mem_to_reg are set, the access is treated as a store.
- Size select: ls_byte has priority over half; neither set means word.
- Addressing: dmem_addr = {addr[31:2],2'b00}.
  - Byte: dmem_be = 4'b0001 << addr[1:0].
  - Half: dmem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: dmem_be = 4'b1111.
- Write data: byte → {4{store_data[7:0]}}; half → {2{store_data[15:0]}}; word → store_data.
- Load extraction: select the lane using addr[1:0] for byte and addr[1] for half. Sign-extend unless load_unsigned=1. Word loads ignore load_unsigned.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: stall = start (combinational). If start, register addr/be/wdata/we/size/sign fields and go to BUSY. Otherwise stay in IDLE.
  - BUSY: dmem_req=1 and stall=1. dmem_addr, dmem_be, dmem_we and dmem_wdata are driven from the registered fields and held stable until dmem_ready.
    - On dmem_ready=1: register the extracted load_data (loads only) and go to DONE.
    - Else, if the counter equals TIMEOUT: go to DONE with an error flag set.
    - Else: increment the counter.
  - DONE: stall=0, dmem_req=0. load_valid=1 for a load without error; bus_error=1 if the error flag is set. Clear the counter and flag, then return to IDLE unconditionally. The same instruction, still present on the inputs, is never re-issued because the pipeline advances at the end of DONE.
- Latency: minimum 3 cycles per access (IDLE→BUSY→DONE) when dmem_ready=1 on the first BUSY cycle; the pipeline sees 2 stalled cycles.
- load_data holds its last value until the next completed load. On a timeout, load_data is 0 and load_valid stays 0.
- dmem_ready outside BUSY is ignored.
- rst_n asserted in BUSY: immediately drop dmem_req and return to IDLE. The transaction is abandoned; the bus side must tolerate this.
- Bubbles (nop=1) and non-memory instructions: no request and no stall; FSM stays in IDLE.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus request. The FSM goes IDLE→DONE directly (1 stalled cycle) and pulses a 1-bit output misalign_trap in DONE; load_valid stays 0. The port exists only when the macro is defined.
- Undefined: misaligned halfwords use addr[1] only and words ignore addr[1:0], i.e. the access is silently aligned down. No extra port.

Test Plan:
- LB addr=0x103, load_unsigned=0, rdata=0x80FF_1234 granted on the first BUSY cycle → dmem_be=4'b1000; load_data=0xFFFF_FF80 pulsed in cycle 3; stall high for cycles 1–2.
- SH addr=0x202, store_data=0x0000_ABCD, dmem_ready delayed 4 cycles → dmem_wdata=0xABCD_ABCD, dmem_be=4'b1100, dmem_we=1; fields stable across all BUSY cycles; stall high for 5 cycles.
- LHU addr=0x10, rdata=0x1234_F00D → load_data=0x0000_F00D; the same load with load_unsigned=0 → 0xFFFF_F00D.
- LW with dmem_ready never asserted, TIMEOUT=255 → dmem_req high for 256 BUSY cycles, then bus_error pulses for 1 cycle, stall drops and load_valid stays 0.
- rst_n pulsed low mid-BUSY → dmem_req and stall fall in the same cycle (asynchronously); next access after reset completes normally. Bubble (nop=1, mem_to_reg=1) → no req and no stall.
- MEM_MISALIGN_TRAP_EN defined, LW addr=0x6 → no dmem_req, misalign_trap pulse 1 cycle after start. Undefined → dmem_addr=0x4 and the access completes normally.
